instr_realign_fifo: RTL and testbench

Parametrised fetch-side realignment FIFO that sits between the instruction memory port and the decode stage. It accepts word-aligned fetch words through a valid/ready handshake and stores them in a DEPTH-entry circular buffer. At halfword granularity it extracts one instruction per cycle, either a 16-bit compressed instruction or a 32-bit instruction that may straddle two entries. It also supports a redirect flush that restarts fetch at a halfword-aligned target.

---
 rtl/instr_realign_fifo.sv | 84 ++++++++
 tb/tb_instr_realign_fifo.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_realign_fifo.sv
// instr_realign_fifo: word FIFO between fetch and decode that extracts one 16/32-bit instruction per cycle.
// Define RVC_EN for halfword (compressed) extraction; otherwise each entry is one 32-bit instruction.
module instr_realign_fifo #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic [ADDR_WIDTH-1:0]  flush_addr_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [31:0]            in_instr_i,
    input  logic [ADDR_WIDTH-1:0]  in_addr_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [31:0]            out_instr_o,
    output logic [ADDR_WIDTH-1:0]  out_addr_o,
    output logic                   out_compressed_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0] FULL = (IW+1)'(DEPTH);

    logic [31:0]           word_q [DEPTH];
    logic [ADDR_WIDTH-3:0] addr_q [DEPTH];
    logic [IW:0]           wptr_q, wptr_d;
    logic [IW+1:0]         rptr_q, rptr_d, avail;
    logic [IW-1:0]         ridx;
    logic                  is_c, wr_en, rd_en, flush_half, unused_bits;
`ifdef RVC_EN
    logic [IW-1:0]         nidx;
    logic [15:0]           hw0, hw1;
`endif

    always_comb begin
        ridx        = rptr_q[IW:1];
        count_o     = wptr_q - rptr_q[IW+1:1];
        avail       = {wptr_q, 1'b0} - rptr_q;
        in_ready_o  = (count_o < FULL) && !flush_i;
        wr_en       = in_valid_i && in_ready_o;
        out_addr_o  = {addr_q[ridx], rptr_q[0], 1'b0};
        unused_bits = ^{in_addr_i[1:0], flush_addr_i};
`ifdef RVC_EN
        nidx             = ridx + IW'(1);
        hw0              = rptr_q[0] ? word_q[ridx][31:16] : word_q[ridx][15:0];
        hw1              = rptr_q[0] ? word_q[nidx][15:0] : word_q[ridx][31:16];
        is_c             = hw0[1:0] != 2'b11;
        out_valid_o      = !flush_i && (is_c ? avail != '0 : avail > (IW+2)'(1));
        out_instr_o      = is_c ? {16'h0, hw0} : {hw1, hw0};
        // hw0 of an empty FIFO decodes as compressed; only report it for a real instruction
        out_compressed_o = out_valid_o && is_c;
        flush_half       = flush_addr_i[1];
`else
        is_c             = 1'b0;
        out_valid_o      = !flush_i && count_o != '0;
        out_instr_o      = word_q[ridx];
        out_compressed_o = 1'b0;
        flush_half       = 1'b0;
`endif
        rd_en  = out_valid_o && out_ready_i;
        rptr_d = flush_i ? {{(IW+1){1'b0}}, flush_half}
                         : rptr_q + (rd_en ? {{IW{1'b0}}, !is_c, is_c} : '0);
        wptr_d = flush_i ? '0 : wptr_q + {{IW{1'b0}}, wr_en};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (wr_en) begin
                word_q[wptr_q[IW-1:0]] <= in_instr_i;
                addr_q[wptr_q[IW-1:0]] <= in_addr_i[ADDR_WIDTH-1:2];
            end
        end
    end
endmodule

// File: tb/tb_instr_realign_fifo.sv
// tb_instr_realign_fifo: directed table, hand sequences and randomized streams against a halfword-parsing model.
// Expectations follow RVC_EN the same way the design build does.
module tb_instr_realign_fifo;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
`ifdef RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, flush_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
    logic [AW-1:0] flush_addr_i = '0, in_addr_i = '0, out_addr_o;
    logic [31:0]   in_instr_i = '0, out_instr_o;
    logic          in_ready_o, out_valid_o, out_compressed_o;
    logic [2:0]    count_o;
    int            n_tests = 0, n_fail = 0;

    typedef struct { logic [31:0] instr; logic [31:0] addr; logic c; } exp_t;
    typedef struct {
        logic [31:0] w0, w1, a; logic h; int nw;
        logic v; logic [31:0] e_instr, e_addr; logic e_c;
    } vec_t;

    exp_t        exp_q[$];
    logic [31:0] words_q[$];
    bit          mon_en = 1'b0;
    vec_t        tbl[8];

    always #5 clk = ~clk;

    instr_realign_fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .flush_addr_i(flush_addr_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_instr_i(in_instr_i), .in_addr_i(in_addr_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_instr_o(out_instr_o),
        .out_addr_o(out_addr_o), .out_compressed_o(out_compressed_o), .count_o(count_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string n, input logic [31:0] i, input logic [31:0] a, input logic c);
        chk({n, " valid"}, 32'(out_valid_o), 32'd1);
        chk({n, " instr"}, out_instr_o, i);
        chk({n, " addr"}, out_addr_o, a);
        chk({n, " compressed"}, 32'(out_compressed_o), 32'(c));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w, input logic [31:0] a);
        in_valid_i = 1'b1;
        in_instr_i = w;
        in_addr_i  = a;
        cyc();
        in_valid_i = 1'b0;
    endtask

    task automatic do_flush(input logic [31:0] a);
        flush_i      = 1'b1;
        flush_addr_i = a;
        cyc();
        flush_i = 1'b0;
    endtask

    // Scoreboard: every accepted instruction must match the head of the expected queue.
    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rnd extra: got %h at %h, expected no instruction", out_instr_o, out_addr_o);
            end else begin
                e = exp_q.pop_front();
                chk("rnd instr", out_instr_o, e.instr);
                chk("rnd addr", out_addr_o, e.addr);
                chk("rnd compressed", 32'(out_compressed_o), 32'(e.c));
            end
        end
    end

    function automatic logic [15:0] rnd_hw();
        logic [15:0] v = 16'($urandom);
        if ($urandom % 2 == 0) v[1:0] = 2'b11;
        else v[1:0] = 2'($urandom % 3);
        return v;
    endfunction

    // Parses words_q as a halfword stream starting at base/h; returns the expected leftover entry count.
    function automatic int model(input logic [31:0] base, input logic h);
        logic [15:0] hws[$];
        int          pos;
        exp_t        e;
        if (!RVC) begin
            foreach (words_q[i]) begin
                e = '{words_q[i], base + 32'(4 * i), 1'b0};
                exp_q.push_back(e);
            end
            return 0;
        end
        foreach (words_q[i]) begin
            hws.push_back(words_q[i][15:0]);
            hws.push_back(words_q[i][31:16]);
        end
        pos = int'(h);
        while (pos < hws.size()) begin
            if (hws[pos][1:0] != 2'b11) begin
                e = '{{16'h0, hws[pos]}, base + 32'(2 * pos), 1'b1};
                pos += 1;
            end else if (pos + 1 < hws.size()) begin
                e = '{{hws[pos+1], hws[pos]}, base + 32'(2 * pos), 1'b0};
                pos += 2;
            end else break;
            exp_q.push_back(e);
        end
        return (pos < hws.size()) ? 1 : 0;
    endfunction

    task automatic rnd_run(input int nw, input logic [31:0] base, input logic h, input bit rand_ready);
        int idx = 0, cycles = 0, left;
        bit acc;
        words_q.delete();
        exp_q.delete();
        for (int i = 0; i < nw; i++) words_q.push_back({rnd_hw(), rnd_hw()});
        left = model(base, h);
        out_ready_i = 1'b0;
        do_flush(base | {30'b0, h, 1'b0});
        mon_en = 1'b1;
        while ((idx < nw || exp_q.size() > 0) && cycles < 500) begin
            out_ready_i = rand_ready ? 1'($urandom) : !out_ready_i;
            in_valid_i  = (idx < nw) && ($urandom % 2 == 1);
            in_instr_i  = (idx < nw) ? words_q[idx] : 32'h0;
            in_addr_i   = base + 32'(4 * idx);
            #1;
            acc = in_valid_i && in_ready_o;
            cyc();
            if (acc) idx++;
            cycles++;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        mon_en      = 1'b0;
        #1;
        chk("rnd words pushed", 32'(idx), 32'(nw));
        chk("rnd drained", 32'(exp_q.size()), 32'd0);
        chk("rnd leftover count", 32'(count_o), 32'(left));
    endtask

    initial begin
        if (RVC) begin
            tbl[0] = '{32'h0000_0013, 32'h0, 32'h1000, 1'b0, 1, 1'b1, 32'h0000_0013, 32'h1000, 1'b0};
            tbl[1] = '{32'hABCD_1235, 32'h0, 32'h2000, 1'b0, 1, 1'b1, 32'h0000_1235, 32'h2000, 1'b1};
            tbl[2] = '{32'hABCD_1235, 32'h0, 32'h2000, 1'b1, 1, 1'b1, 32'h0000_ABCD, 32'h2002, 1'b1};
            tbl[3] = '{32'h1234_5677, 32'h0, 32'h3000, 1'b1, 1, 1'b1, 32'h0000_1234, 32'h3002, 1'b1};
            tbl[4] = '{32'h5677_0000, 32'h0, 32'h4000, 1'b1, 1, 1'b0, 32'h0, 32'h0, 1'b0};
            tbl[5] = '{32'h5677_0000, 32'h9999_1234, 32'h4000, 1'b1, 2, 1'b1, 32'h1234_5677, 32'h4002, 1'b0};
            tbl[6] = '{32'hFFFF_FFFF, 32'h0, 32'h5000, 1'b0, 1, 1'b1, 32'hFFFF_FFFF, 32'h5000, 1'b0};
            tbl[7] = '{32'h0000_0002, 32'h0, 32'h6000, 1'b0, 1, 1'b1, 32'h0000_0002, 32'h6000, 1'b1};
        end else begin
            tbl[0] = '{32'h0000_0013, 32'h0, 32'h1000, 1'b0, 1, 1'b1, 32'h0000_0013, 32'h1000, 1'b0};
            tbl[1] = '{32'hABCD_1235, 32'h0, 32'h2000, 1'b0, 1, 1'b1, 32'hABCD_1235, 32'h2000, 1'b0};
            tbl[2] = '{32'hABCD_1235, 32'h0, 32'h2000, 1'b1, 1, 1'b1, 32'hABCD_1235, 32'h2000, 1'b0};
            tbl[3] = '{32'h1234_5677, 32'h0, 32'h3000, 1'b1, 1, 1'b1, 32'h1234_5677, 32'h3000, 1'b0};
            tbl[4] = '{32'h5677_0000, 32'h0, 32'h4000, 1'b1, 1, 1'b1, 32'h5677_0000, 32'h4000, 1'b0};
            tbl[5] = '{32'h5677_0000, 32'h9999_1234, 32'h4000, 1'b1, 2, 1'b1, 32'h5677_0000, 32'h4000, 1'b0};
            tbl[6] = '{32'hFFFF_FFFF, 32'h0, 32'h5000, 1'b0, 1, 1'b1, 32'hFFFF_FFFF, 32'h5000, 1'b0};
            tbl[7] = '{32'h0000_0002, 32'h0, 32'h6000, 1'b0, 1, 1'b1, 32'h0000_0002, 32'h6000, 1'b0};
        end

        // Reset state
        #2;
        chk("reset in_ready", 32'(in_ready_o), 32'd1);
        chk("reset out_valid", 32'(out_valid_o), 32'd0);
        chk("reset out_instr", out_instr_o, 32'h0);
        chk("reset out_addr", out_addr_o, 32'h0);
        chk("reset compressed", 32'(out_compressed_o), 32'd0);
        chk("reset count", 32'(count_o), 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Fill to full, then drain while a refused write is offered
        for (int k = 0; k < 4; k++) push(32'h0000_0013, 32'h100 + 32'(4 * k));
        #1;
        chk("full in_ready", 32'(in_ready_o), 32'd0);
        chk("full count", 32'(count_o), 32'd4);
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        in_instr_i  = 32'hDEAD_BEEF;
        in_addr_i   = 32'h110;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk_out("drain", 32'h0000_0013, 32'h100 + 32'(4 * k), 1'b0);
            cyc();
            in_valid_i = 1'b0;
        end
        #1;
        chk("drain count", 32'(count_o), 32'd0);
        chk("drain valid", 32'(out_valid_o), 32'd0);

`ifdef RVC_EN
        // Two compressed instructions from one word on consecutive cycles
        push(32'h4501_4501, 32'h200);
        #1;
        chk_out("c16 lo", 32'h0000_4501, 32'h200, 1'b1);
        chk("c16 lo count", 32'(count_o), 32'd1);
        cyc();
        chk_out("c16 hi", 32'h0000_4501, 32'h202, 1'b1);
        cyc();
        chk("c16 count", 32'(count_o), 32'd0);

        // 32-bit instruction straddling two entries
        push(32'h0013_4501, 32'h300);
        #1;
        chk_out("strad c", 32'h0000_4501, 32'h300, 1'b1);
        cyc();
        chk("strad wait valid", 32'(out_valid_o), 32'd0);
        chk("strad wait count", 32'(count_o), 32'd1);
        cyc();
        chk("strad wait2 valid", 32'(out_valid_o), 32'd0);
        push(32'h0001_0000, 32'h304);
        #1;
        chk_out("strad i32", 32'h0000_0013, 32'h302, 1'b0);
        cyc();
        chk_out("strad tail", 32'h0000_0001, 32'h306, 1'b1);
        cyc();
        chk("strad count", 32'(count_o), 32'd0);
`else
        push(32'h4501_4501, 32'h500);
        #1;
        chk_out("norvc word", 32'h4501_4501, 32'h500, 1'b0);
        chk("norvc count", 32'(count_o), 32'd1);
        cyc();
        chk("norvc count after", 32'(count_o), 32'd0);
        chk("norvc valid after", 32'(out_valid_o), 32'd0);
`endif

        // Flush with two words queued; handshakes in the flush cycle are void
        out_ready_i = 1'b0;
        push(32'h0000_0013, 32'h700);
        push(32'h0000_0013, 32'h704);
        flush_i      = 1'b1;
        flush_addr_i = 32'h402;
        in_valid_i   = 1'b1;
        in_instr_i   = 32'hCAFE_F00D;
        in_addr_i    = 32'h900;
        out_ready_i  = 1'b1;
        #1;
        chk("flush in_ready", 32'(in_ready_o), 32'd0);
        chk("flush out_valid", 32'(out_valid_o), 32'd0);
        cyc();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        #1;
        chk("post flush count", 32'(count_o), 32'd0);
        chk("post flush valid", 32'(out_valid_o), 32'd0);
        push(32'h4501_0000, 32'h400);
        #1;
        if (RVC) chk_out("flush target", 32'h0000_4501, 32'h402, 1'b1);
        else chk_out("flush target", 32'h4501_0000, 32'h400, 1'b0);
        cyc();
        chk("flush target count", 32'(count_o), 32'd0);

        // Directed table: first output after a flush plus one or two pushes
        out_ready_i = 1'b0;
        foreach (tbl[r]) begin
            do_flush(tbl[r].a | {30'b0, tbl[r].h, 1'b0});
            push(tbl[r].w0, tbl[r].a);
            if (tbl[r].nw == 2) push(tbl[r].w1, tbl[r].a + 32'h4);
            #1;
            chk($sformatf("tbl%0d count", r), 32'(count_o), 32'(tbl[r].nw));
            if (tbl[r].v) chk_out($sformatf("tbl%0d", r), tbl[r].e_instr, tbl[r].e_addr, tbl[r].e_c);
            else chk($sformatf("tbl%0d valid", r), 32'(out_valid_o), 32'd0);
        end

        // Random streams spanning several pointer wraps
        rnd_run(12, 32'h0000_1000, 1'b0, 1'b0);
        rnd_run(12, 32'h0000_2000, 1'b1, 1'b0);
        rnd_run(16, 32'h0000_3000, 1'b0, 1'b1);
        rnd_run(20, 32'h0000_4000, 1'b1, 1'b1);

        // Asynchronous reset mid-stream
        out_ready_i = 1'b0;
        push(32'h1111_1113, 32'h800);
        push(32'h2222_2223, 32'h804);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst count", 32'(count_o), 32'd0);
        chk("midrst valid", 32'(out_valid_o), 32'd0);
        chk("midrst in_ready", 32'(in_ready_o), 32'd1);
        chk("midrst instr", out_instr_o, 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("midrst count after", 32'(count_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end
endmodule
